// File: rtl/pc_branch_unit.sv
// Program counter with increment, absolute jump and conditional relative branch.
// Relative branches that cross a page take one extra cycle to correct the high part.
//
// state | meaning
// RUN   | accepting inc / jump / conditional branch commands
// FIX   | applying the +1/-1 correction to the PC high part; commands ignored
module pc_branch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter int                FLAG_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       load_lo,
  input  logic                       branch_uncon,
  input  logic                       branch_con,
  input  logic [$clog2(FLAG_W)-1:0]  branch_sel,
  input  logic                       branch_sense,
  input  logic [FLAG_W-1:0]          status,
  input  logic [DATA_W-1:0]          data_in,
  output logic [ADDR_W-1:0]          address,
  output logic                       busy,
  output logic                       taken,
  output logic                       normal,
  output logic                       page_cross
);

  localparam int HI_W = ADDR_W - DATA_W;

  typedef enum logic {RUN, FIX} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [DATA_W-1:0] lo_hold, lo_hold_nx;
  logic              fix_down, fix_down_nx;
  logic              taken_nx, normal_nx, page_cross_nx;

  logic              cond;
  logic [DATA_W:0]   lo_sum;
  logic              off_neg;
  logic              carry;
  logic              need_fix;
  logic [HI_W-1:0]   pc_hi;
  logic [HI_W-1:0]   pc_hi_fixed;

  assign cond        = (status[branch_sel] == branch_sense);
  assign lo_sum      = {1'b0, pc[DATA_W-1:0]} + {1'b0, data_in};
  assign off_neg     = data_in[DATA_W-1];
  assign carry       = lo_sum[DATA_W];
  // carry with a positive offset or no carry with a negative one means the page changed
  assign need_fix    = carry ^ off_neg;
  assign pc_hi       = pc[ADDR_W-1:DATA_W];
  assign pc_hi_fixed = fix_down ? (pc_hi - HI_W'(1)) : (pc_hi + HI_W'(1));

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    lo_hold_nx    = load_lo ? data_in : lo_hold;
    fix_down_nx   = fix_down;
    taken_nx      = 1'b0;
    normal_nx     = 1'b0;
    page_cross_nx = 1'b0;

    unique case (state)
      RUN: begin
        if (branch_uncon) begin
          // jump uses the lo_hold value from before any coincident load_lo
          pc_nx = {data_in[HI_W-1:0], lo_hold};
        end else if (branch_con) begin
          if (cond) begin
            taken_nx = 1'b1;
            pc_nx    = {pc_hi, lo_sum[DATA_W-1:0]};
            if (need_fix) begin
              page_cross_nx = 1'b1;
              fix_down_nx   = off_neg;
              state_nx      = FIX;
            end
          end else begin
            normal_nx = 1'b1;
          end
        end else if (inc) begin
          pc_nx = pc + ADDR_W'(1);
        end
      end
      FIX: begin
        pc_nx       = {pc_hi_fixed, pc[DATA_W-1:0]};
        fix_down_nx = 1'b0;
        state_nx    = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= RESET_ADDR;
      lo_hold    <= '0;
      fix_down   <= 1'b0;
      busy       <= 1'b0;
      taken      <= 1'b0;
      normal     <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      lo_hold    <= lo_hold_nx;
      fix_down   <= fix_down_nx;
      busy       <= (state_nx == FIX);
      taken      <= taken_nx;
      normal     <= normal_nx;
      page_cross <= page_cross_nx;
    end
  end

  assign address = pc;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a target-address reference model queues the
// expected outputs per cycle, and an independent monitor compares them after each edge.
module tb_pc_branch_unit;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int FLAG_W = 8;
  localparam logic [ADDR_W-1:0] RESET_ADDR = 16'h0000;
  localparam int PC_MOD  = 1 << ADDR_W;
  localparam int LO_MASK = (1 << DATA_W) - 1;
  localparam int HI_MASK = (1 << (ADDR_W - DATA_W)) - 1;

  logic              clk = 1'b0;
  logic              rst, inc, load_lo, branch_uncon, branch_con, branch_sense;
  logic [2:0]        branch_sel;
  logic [FLAG_W-1:0] status;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] address;
  logic              busy, taken, normal, page_cross;

  pc_branch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FLAG_W(FLAG_W), .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .inc(inc), .load_lo(load_lo),
    .branch_uncon(branch_uncon), .branch_con(branch_con),
    .branch_sel(branch_sel), .branch_sense(branch_sense),
    .status(status), .data_in(data_in), .address(address),
    .busy(busy), .taken(taken), .normal(normal), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    pc;
    bit    busy;
    bit    taken;
    bit    normal;
    bit    page_cross;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // reference model: PC as an integer, plus the final target of a pending page fix
  int m_pc     = 0;
  int m_lo     = 0;
  int m_target = 0;
  bit m_in_fix = 0;

  task automatic chk(input string name, input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%s] at %0t: got %h, expected %h", name, tag, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit i, input bit l, input bit u, input bit c,
                      input int sel, input bit sense, input int st, input int d,
                      input string tag);
    exp_t e;
    int   old_lo, off, full;
    @(negedge clk);
    rst = r; inc = i; load_lo = l; branch_uncon = u; branch_con = c;
    branch_sel = 3'(sel); branch_sense = sense; status = 8'(st); data_in = 8'(d);
    e.busy = 0; e.taken = 0; e.normal = 0; e.page_cross = 0; e.tag = tag;
    if (!r) begin
      m_pc = int'(RESET_ADDR); m_lo = 0; m_in_fix = 0;
    end else begin
      old_lo = m_lo;
      if (l) m_lo = d;
      if (m_in_fix) begin
        m_pc = m_target;
        m_in_fix = 0;
      end else if (u) begin
        m_pc = ((d & HI_MASK) << DATA_W) | old_lo;
      end else if (c) begin
        if (((st >> sel) & 1) == int'(sense)) begin
          off  = (d >= (1 << (DATA_W - 1))) ? d - (1 << DATA_W) : d;
          full = (m_pc + off + PC_MOD) % PC_MOD;
          e.taken = 1;
          if ((full >> DATA_W) != (m_pc >> DATA_W)) begin
            e.page_cross = 1; e.busy = 1;
            m_in_fix = 1; m_target = full;
            m_pc = (m_pc & ~LO_MASK) | (full & LO_MASK);
          end else begin
            m_pc = full;
          end
        end else begin
          e.normal = 1;
        end
      end else if (i) begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
    e.pc = m_pc;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic set_pc(input int v);
    step(1, 0, 1, 0, 0, 0, 0, 0, v & LO_MASK, "set_lo");
    step(1, 0, 0, 1, 0, 0, 0, 0, (v >> DATA_W) & HI_MASK, "set_hi");
  endtask

  // conditional branch on status bit 0 = 1; sense picks taken / not taken
  task automatic bcond(input bit take, input int d, input string tag);
    step(1, 0, 0, 0, 1, 0, take, 8'h01, d, tag);
  endtask

  // direct check against a fixed address right after the edge the last step feeds
  task automatic expect_pc(input string tag, input int v);
    @(posedge clk);
    #2;
    chk("addr_const", tag, 32'(address), 32'(v));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("address",    e.tag, 32'(address),    32'(e.pc));
        chk("busy",       e.tag, 32'(busy),       32'(e.busy));
        chk("taken",      e.tag, 32'(taken),      32'(e.taken));
        chk("normal",     e.tag, 32'(normal),     32'(e.normal));
        chk("page_cross", e.tag, 32'(page_cross), 32'(e.page_cross));
      end
    end
  end

  initial begin : stimulus
    int k;
    rst = 0; inc = 0; load_lo = 0; branch_uncon = 0; branch_con = 0;
    branch_sel = 0; branch_sense = 0; status = 0; data_in = 0;

    step(0, 1, 1, 1, 1, 0, 0, 8'hFF, 8'hAB, "reset");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, "reset");
    expect_pc("reset", 16'h0000);

    set_pc(16'hFFFF);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, "inc_wrap");
    expect_pc("inc_wrap", 16'h0000);

    step(1, 0, 1, 0, 0, 0, 0, 0, 8'h34, "load_lo");
    step(1, 0, 0, 1, 0, 0, 0, 0, 8'h12, "jump");
    expect_pc("jump", 16'h1234);
    step(1, 0, 1, 1, 0, 0, 0, 0, 8'h77, "jump_old_lo");
    expect_pc("jump_old_lo", 16'h7734);
    step(1, 1, 0, 1, 0, 0, 0, 0, 8'h22, "jump_and_inc");
    expect_pc("jump_and_inc", 16'h2277);

    set_pc(16'h10F0);
    bcond(1, 8'h20, "fwd_cross");
    expect_pc("fwd_cross", 16'h1010);
    step(1, 1, 0, 1, 1, 0, 1, 8'h01, 8'h40, "fix_ignores_cmds");
    expect_pc("fix_ignores_cmds", 16'h1110);
    idle("after_fix");

    set_pc(16'h1005);
    bcond(1, 8'hF0, "back_cross");
    expect_pc("back_cross", 16'h10F5);
    idle("back_fix");
    expect_pc("back_fix", 16'h0FF5);
    idle("after_back_fix");

    bcond(1, 8'hF0, "back_no_cross");
    expect_pc("back_no_cross", 16'h0FE5);

    set_pc(16'h1010);
    bcond(1, 8'h05, "fwd_no_cross");
    expect_pc("fwd_no_cross", 16'h1015);
    set_pc(16'h1010);
    bcond(0, 8'h05, "not_taken");
    expect_pc("not_taken", 16'h1010);
    step(1, 0, 0, 0, 1, 5, 0, 8'hDF, 8'h05, "sel5_sense0_taken");
    expect_pc("sel5_sense0_taken", 16'h1015);

    set_pc(16'hFFF0);
    bcond(1, 8'h20, "hi_wrap");
    idle("hi_wrap_fix");
    expect_pc("hi_wrap_fix", 16'h0010);

    set_pc(16'h10F0);
    bcond(1, 8'h20, "cross_then_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_in_fix");
    expect_pc("rst_in_fix", 16'h0000);
    idle("after_rst_fix");

    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 60) != 0, $urandom % 2, ($urandom % 4) == 0,
           ($urandom % 8) == 0, ($urandom % 3) == 0, $urandom % 8, $urandom % 2,
           $urandom % 256, $urandom % 256, "random");
    end

    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #3;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
